fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 114 +++++++++++
 tb/tb_fetch_unit.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC generator feeding a small FIFO of {instruction, address}.
// Optional stall-cycle performance counter enabled by defining FETCH_PERF_CNT_EN.

package fetch_pkg;
  localparam int WORD_SIZE_P   = 16;
  localparam int I_ROM_DEPTH_P = 256;
endpackage

module fetch_unit
  import fetch_pkg::*;
#(
  parameter  int RESET_PC_P    = 0,
  parameter  int QUEUE_ELS_P   = 2,
  localparam int ADDR_WIDTH_LP = $clog2(I_ROM_DEPTH_P)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  output logic [ADDR_WIDTH_LP-1:0] rom_addr_o,
  input  logic [WORD_SIZE_P-1:0]   rom_data_i,
  input  logic                     redirect_v_i,
  input  logic [ADDR_WIDTH_LP-1:0] redirect_pc_i,
  output logic                     instr_v_o,
  output logic [WORD_SIZE_P-1:0]   instr_o,
  output logic [ADDR_WIDTH_LP-1:0] instr_pc_o,
  input  logic                     instr_yumi_i
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]              stall_cnt_o
`endif
);

  localparam int PTR_W = $clog2(QUEUE_ELS_P);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_WIDTH_LP-1:0] pc_r;
  logic [ADDR_WIDTH_LP-1:0] next_pc;
  logic [PTR_W-1:0]         wr_ptr_r;
  logic [PTR_W-1:0]         rd_ptr_r;
  logic [PTR_W-1:0]         wr_idx;
  logic [CNT_W-1:0]         count_r;
  logic                     full;
  logic                     empty;
  logic                     enq;
  logic                     deq;

  logic [WORD_SIZE_P-1:0]   instr_mem [QUEUE_ELS_P];
  logic [ADDR_WIDTH_LP-1:0] pc_mem    [QUEUE_ELS_P];

  assign full  = (count_r == CNT_W'(QUEUE_ELS_P));
  assign empty = (count_r == '0);

  // A redirect overrides the sequential PC in the same cycle the ROM is read.
  assign rom_addr_o = redirect_v_i ? redirect_pc_i : pc_r;
  assign next_pc    = (rom_addr_o == ADDR_WIDTH_LP'(I_ROM_DEPTH_P - 1))
                    ? '0 : rom_addr_o + ADDR_WIDTH_LP'(1);

  // A slot frees up when decode consumes the head or a redirect flushes the queue.
  assign enq = !reset_i && (!full || instr_yumi_i || redirect_v_i);
  assign deq = !reset_i && instr_yumi_i && !empty;

  // A redirect restarts the queue at slot 0 so the target becomes the head.
  assign wr_idx = redirect_v_i ? '0 : wr_ptr_r;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pc_r     <= ADDR_WIDTH_LP'(RESET_PC_P);
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (enq) pc_r <= next_pc;
      if (redirect_v_i) begin
        wr_ptr_r <= PTR_W'(1);
        rd_ptr_r <= '0;
        count_r  <= CNT_W'(1);
      end else begin
        if (enq) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
        if (deq) rd_ptr_r <= rd_ptr_r + PTR_W'(1);
        count_r <= count_r + CNT_W'(enq) - CNT_W'(deq);
      end
    end
  end

  // NOTE: queue storage is not reset; count_r alone decides which slots are meaningful.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      instr_mem[wr_idx] <= rom_data_i;
      pc_mem[wr_idx]    <= rom_addr_o;
    end
  end

  assign instr_v_o  = !empty;
  assign instr_o    = instr_mem[rd_ptr_r];
  assign instr_pc_o = pc_mem[rd_ptr_r];

`ifdef FETCH_PERF_CNT_EN
  logic stall;
  assign stall = !reset_i && full && !instr_yumi_i && !redirect_v_i;

  always_ff @(posedge clk_i) begin
    if (reset_i)
      stall_cnt_o <= '0;
    else if (stall && (stall_cnt_o != '1))
      stall_cnt_o <= stall_cnt_o + 32'd1;
  end
`endif

  // Consuming from an empty queue is a decode protocol error; the request is ignored.
  illegal_yumi_a : assert property (@(posedge clk_i) disable iff (reset_i)
    !(instr_yumi_i && empty))
    else $warning("instr_yumi_i asserted with empty fetch queue; request ignored");

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: hand-derived vector table plus a queue-based reference scoreboard,
// followed by a random stream of consumes and redirects checked against the scoreboard.

module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int AW = $clog2(I_ROM_DEPTH_P);
  localparam int Q  = 2;

  logic                   clk = 1'b0;
  logic                   reset_i = 1'b1;
  logic [AW-1:0]          rom_addr_o;
  logic [WORD_SIZE_P-1:0] rom_data_i;
  logic                   redirect_v_i = 1'b0;
  logic [AW-1:0]          redirect_pc_i = '0;
  logic                   instr_v_o;
  logic [WORD_SIZE_P-1:0] instr_o;
  logic [AW-1:0]          instr_pc_o;
  logic                   instr_yumi_i = 1'b0;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]            stall_cnt_o;
`endif

  always #5 clk = ~clk;

  // ROM image: word n holds 16'hA000 + n.
  assign rom_data_i = 16'hA000 + {8'h00, rom_addr_o};

  fetch_unit #(.RESET_PC_P(0), .QUEUE_ELS_P(Q)) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .rom_addr_o   (rom_addr_o),
    .rom_data_i   (rom_data_i),
    .redirect_v_i (redirect_v_i),
    .redirect_pc_i(redirect_pc_i),
    .instr_v_o    (instr_v_o),
    .instr_o      (instr_o),
    .instr_pc_o   (instr_pc_o),
    .instr_yumi_i (instr_yumi_i)
`ifdef FETCH_PERF_CNT_EN
    ,
    .stall_cnt_o  (stall_cnt_o)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] m_pc = '0;
  logic [AW-1:0] addr_seen;

  typedef struct {
    logic          rst;
    logic          rv;
    logic [AW-1:0] rpc;
    logic          y;
    logic [AW-1:0] addr;
    logic          v;
    logic [AW-1:0] pc;
  } vec_t;

  localparam int NV = 27;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: drive inputs after the falling edge, check the combinational address,
  // advance the scoreboard, then compare the registered head just after the rising edge.
  task automatic step(input logic r, input logic rv, input logic [AW-1:0] rpc, input logic y);
    logic [AW-1:0] addr;
    logic          enq;
    @(negedge clk);
    reset_i       = r;
    redirect_v_i  = rv;
    redirect_pc_i = rpc;
    instr_yumi_i  = y;
    #1;
    addr      = rv ? rpc : m_pc;
    addr_seen = rom_addr_o;
    if (!r) check("sb.rom_addr", 32'(rom_addr_o), 32'(addr));
    if (r) begin
      exp_q.delete();
      m_pc = '0;
    end else begin
      enq = (exp_q.size() < Q) || y || rv;
      if (rv) exp_q.delete();
      else if (y && exp_q.size() > 0) void'(exp_q.pop_front());
      if (enq) begin
        exp_q.push_back(addr);
        m_pc = addr + AW'(1);
      end
    end
    @(posedge clk);
    #1;
    check("sb.instr_v", 32'(instr_v_o), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check("sb.instr_pc", 32'(instr_pc_o), 32'(exp_q[0]));
      check("sb.instr", 32'(instr_o), 32'(16'hA000 + {8'h00, exp_q[0]}));
    end
  endtask

  initial begin
    // Streaming with yumi held high.
    vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00};
    vecs[1]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 8'h00};
    vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h01, 1'b1, 8'h01};
    vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h02, 1'b1, 8'h02};
    vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h03, 1'b1, 8'h03};
    // Backpressure: fill to two entries, then three stall cycles, then drain in order.
    vecs[5]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00};
    vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h01, 1'b1, 8'h00};
    vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h02, 1'b1, 8'h00};
    vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h02, 1'b1, 8'h00};
    vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h02, 1'b1, 8'h00};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h02, 1'b1, 8'h01};
    vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h03, 1'b1, 8'h02};
    vecs[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h04, 1'b1, 8'h03};
    // Redirect with two entries queued, then the following fetch.
    vecs[14] = '{1'b0, 1'b1, 8'h40, 1'b0, 8'h40, 1'b1, 8'h40};
    vecs[15] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h41, 1'b1, 8'h41};
    // Wrap from the top of the ROM.
    vecs[16] = '{1'b0, 1'b1, 8'hFE, 1'b1, 8'hFE, 1'b1, 8'hFE};
    vecs[17] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'hFF, 1'b1, 8'hFF};
    vecs[18] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 8'h00};
    vecs[19] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h01, 1'b1, 8'h01};
    // Reset pulse with two entries queued.
    vecs[20] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h02, 1'b1, 8'h01};
    vecs[21] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00};
    vecs[22] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00};
    // Yumi on an empty queue must not pop anything.
    vecs[23] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00};
    vecs[24] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 8'h00};
    vecs[25] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h01, 1'b1, 8'h00};
    vecs[26] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h02, 1'b1, 8'h01};

    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);

    for (int i = 0; i < NV; i++) begin
      step(vecs[i].rst, vecs[i].rv, vecs[i].rpc, vecs[i].y);
      if (!vecs[i].rst)
        check($sformatf("v%0d.rom_addr", i), 32'(addr_seen), 32'(vecs[i].addr));
      check($sformatf("v%0d.instr_v", i), 32'(instr_v_o), 32'(vecs[i].v));
      if (vecs[i].v) begin
        check($sformatf("v%0d.instr_pc", i), 32'(instr_pc_o), 32'(vecs[i].pc));
        check($sformatf("v%0d.instr", i), 32'(instr_o), 32'(16'hA000 + {8'h00, vecs[i].pc}));
      end
`ifdef FETCH_PERF_CNT_EN
      if (i == 10) check("stall_cnt_after_backpressure", stall_cnt_o, 32'd3);
      if (i == 21) check("stall_cnt_reset", stall_cnt_o, 32'd0);
`endif
    end

    // Random legal traffic: consumes only while the reference queue holds entries.
    for (int i = 0; i < 300; i++) begin
      logic          y;
      logic          rv;
      logic [AW-1:0] rpc;
      y   = (exp_q.size() != 0) && ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 15) == 0);
      rpc = AW'($urandom_range(0, I_ROM_DEPTH_P - 1));
      step(1'b0, rv, rpc, y);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
